// File: rtl/reg_file_sb.sv
// Register file with a pending-bit scoreboard and a power-up clearing sweep.
// After reset, INIT clears one register per cycle. RUN then accepts writeback,
// issue and flush traffic. Both read ports bypass a same-cycle writeback.
module reg_file_sb #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     o_ready,
  input  logic                     i_wr_en,
  input  logic [$clog2(NREGS)-1:0] i_wr_addr,
  input  logic [XLEN-1:0]          i_wr_data,
  input  logic                     i_iss_en,
  input  logic [$clog2(NREGS)-1:0] i_iss_addr,
  input  logic                     i_flush,
  input  logic [$clog2(NREGS)-1:0] i_rd_addr_a,
  input  logic [$clog2(NREGS)-1:0] i_rd_addr_b,
  output logic [XLEN-1:0]          o_rd_data_a,
  output logic [XLEN-1:0]          o_rd_data_b,
  output logic                     o_rd_busy_a,
  output logic                     o_rd_busy_b
);

  localparam int unsigned AW = $clog2(NREGS);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e              r_state;
  state_e              w_state_next;
  logic [AW-1:0]       r_init_cnt;
  logic [AW-1:0]       w_init_cnt_next;
  logic [XLEN-1:0]     r_regs [NREGS];
  logic [NREGS-1:0]    r_pending;
  logic [NREGS-1:0]    w_pending_next;
  logic                w_run;
  logic                w_wr_ok;

  assign w_run   = (r_state == StRun);
  // Writes are only honoured in RUN; register 0 is hardwired to zero.
  assign w_wr_ok = w_run && i_wr_en && (i_wr_addr != '0);
  assign o_ready = w_run;

  // State and init-counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StInit;
      r_init_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_init_cnt <= w_init_cnt_next;
    end
  end

  // Next state: sweep every index once, then stay in RUN until reset.
  always_comb begin
    w_state_next    = r_state;
    w_init_cnt_next = r_init_cnt;
    unique case (r_state)
      StInit: begin
        w_init_cnt_next = r_init_cnt + 1'b1;
        if (r_init_cnt == AW'(NREGS - 1)) begin
          w_state_next = StRun;
        end
      end
      StRun: begin
        w_state_next = StRun;
      end
      default: begin
        w_state_next = StInit;
      end
    endcase
  end

  // Register storage: cleared by the sweep, written by writeback in RUN.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == StInit) begin
        r_regs[r_init_cnt] <= '0;
      end else if (w_wr_ok) begin
        r_regs[i_wr_addr] <= i_wr_data;
      end
    end
  end

  // Scoreboard next value: flush, then writeback clear, then issue set (set wins).
  always_comb begin
    w_pending_next = r_pending;
    if (w_run) begin
      if (i_flush) begin
        w_pending_next = '0;
      end
      if (i_wr_en) begin
        w_pending_next[i_wr_addr] = 1'b0;
      end
      if (i_iss_en) begin
        w_pending_next[i_iss_addr] = 1'b1;
      end
    end
    w_pending_next[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_next;
    end
  end

  // Read ports with writeback bypass; a same-cycle writeback satisfies the operand.
  always_comb begin
    o_rd_data_a = '0;
    o_rd_data_b = '0;
    o_rd_busy_a = 1'b0;
    o_rd_busy_b = 1'b0;
    if (w_run) begin
      if (i_rd_addr_a != '0) begin
        if (w_wr_ok && (i_wr_addr == i_rd_addr_a)) begin
          o_rd_data_a = i_wr_data;
        end else begin
          o_rd_data_a = r_regs[i_rd_addr_a];
          o_rd_busy_a = r_pending[i_rd_addr_a];
        end
      end
      if (i_rd_addr_b != '0) begin
        if (w_wr_ok && (i_wr_addr == i_rd_addr_b)) begin
          o_rd_data_b = i_wr_data;
        end else begin
          o_rd_data_b = r_regs[i_rd_addr_b];
          o_rd_busy_b = r_pending[i_rd_addr_b];
        end
      end
    end
  end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameter XLEN, default 32, data width of each register.
REQ-002 Parameter NREGS, default 32, register count; power of two, at least 2; address width AW = log2(NREGS).
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 ready  out  1  high when initialisation is complete and the file accepts traffic.
REQ-006 wr_en  in  1  writeback strobe.
REQ-007 wr_addr  in  AW  writeback register index.
REQ-008 wr_data  in  XLEN  writeback data.
REQ-009 iss_en  in  1  issue strobe; marks iss_addr pending.
REQ-010 iss_addr  in  AW  destination register of the issuing instruction.
REQ-011 flush  in  1  clears all pending bits.
REQ-012 rd_addr_a / rd_addr_b  in  AW  read port A/B index.
REQ-013 rd_data_a / rd_data_b  out  XLEN  read port A/B data, combinational.
REQ-014 rd_busy_a / rd_busy_b  out  1  read port A/B operand-not-ready flag, combinational.

Function
REQ-015 The block SHALL have two states: INIT (ready=0) and RUN (ready=1).
REQ-016 In INIT, a counter SHALL clear one register per cycle, indices 0..NREGS-1 in order, then enter RUN; ready rises exactly NREGS cycles after reset deasserts.
REQ-017 In INIT, wr_en, iss_en and flush SHALL be ignored; rd_data_* SHALL read 0; rd_busy_* SHALL read 0.
REQ-018 Register 0 SHALL always read 0, never be written, and never report busy.
REQ-019 In RUN, wr_en with wr_addr!=0 SHALL update the register at the next rising edge.
REQ-020 Bypass: if wr_en and wr_addr==rd_addr_x and rd_addr_x!=0, rd_data_x SHALL equal wr_data in the same cycle.
REQ-021 Both read ports SHALL be independent; identical addresses on A and B SHALL return identical data.
REQ-022 Scoreboard: one pending bit per register; iss_en SHALL set pending[iss_addr] (iss_addr!=0) at the next edge.
REQ-023 wr_en SHALL clear pending[wr_addr] at the next edge.
REQ-024 Simultaneous iss_en and wr_en to the same register: set SHALL win (pending remains 1).
REQ-025 flush SHALL clear all pending bits at the next edge; an iss_en in the same cycle SHALL still set its bit; wr_en in the same cycle SHALL still update data.
REQ-026 rd_busy_x SHALL equal pending[rd_addr_x] AND NOT (wr_en AND wr_addr==rd_addr_x); a same-cycle writeback satisfies the operand.
REQ-027 The block SHALL produce no X on outputs for any in-range input; out-of-range address cannot occur (AW exact).

Reset
REQ-028 reset asserted in any state SHALL, at the next edge, clear all pending bits, reset the init counter to 0 and enter INIT; ready SHALL be 0 in the cycle following that edge.
REQ-029 Reset during INIT SHALL restart the sweep from index 0.
REQ-030 Register contents SHALL be 0 for every index once ready rises.

Verification
REQ-031 Reset 1 cycle, release -> ready=0 for 32 cycles, ready=1 on cycle 32; read all 32 registers -> 0.
REQ-032 RUN: wr_en, addr 5, data 0xDEADBEEF, rd_addr_a=5 same cycle -> rd_data_a=0xDEADBEEF (bypass); next cycle, wr_en=0 -> still 0xDEADBEEF.
REQ-033 Write addr 0, data 0x12345678; iss_en addr 0 -> rd_data 0, rd_busy 0 thereafter.
REQ-034 iss_en addr 7 -> rd_busy_b(7)=1 next cycle; wr_en addr 7 data 0x55 -> rd_busy_b=0 and rd_data_b=0x55 that cycle; same-cycle iss_en+wr_en addr 7 -> busy stays 1.
REQ-035 Set pending on regs 3,4,9; flush with iss_en addr 9 -> next cycle busy(3)=0, busy(4)=0, busy(9)=1.
REQ-036 Reset asserted 10 cycles into INIT and again in RUN with pending bits set -> sweep restarts, ready low 32 cycles, all busy 0, all data 0.
